sram_pipe: RTL

Byte-addressable synchronous single-read/single-write SRAM. Successor to the basic project SRAM, with these additions:
- configurable read latency and a RD_VALID strobe
- write-first byte-merge forwarding on same-word read/write collisions
- optional zero-clear sweep of the array after reset, with a READY flag
Serves as the instruction/data backing store behind the processor memory interface.

---
 rtl/sram_pipe_pkg.sv | 21 ++
 rtl/sram_rd_pipe.sv | 58 +++++
 rtl/sram_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sram_pipe_pkg.sv
// Shared types and helpers for the pipelined byte-enable SRAM.
// Exports: state_t, MAX_READ_LATENCY, byte_parity(), words_of().
package sram_pipe_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int MAX_READ_LATENCY = 4;

    // Even parity: stored bit makes the 9-bit group have an even count.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic int words_of(input int aw, input int dw);
        return 1 << (aw - dw);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line of `stages` registers carrying {data, perr, valid}.
// Ports: CLK, RST (sync flush), in_* from stage 1, out_* to the top outputs.
module sram_rd_pipe #(
    parameter int stages = 0,
    parameter int width  = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    input  logic             in_perr,
    output logic             out_valid,
    output logic [width-1:0] out_data,
    output logic             out_perr
);

    generate
        if (stages == 0) begin : g_pass
            logic unused_pins;
            assign unused_pins = CLK ^ RST;
            assign out_valid   = in_valid;
            assign out_data    = in_data;
            assign out_perr    = in_perr;
        end else begin : g_dly
            logic [stages-1:0] v_q;
            logic [stages-1:0] p_q;
            logic [width-1:0]  d_q [stages];

            // Data only moves with its valid so the tail holds the
            // last delivered word between reads.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    v_q <= '0;
                    p_q <= '0;
                    for (int i = 0; i < stages; i++) d_q[i] <= '0;
                end else begin
                    v_q[0] <= in_valid;
                    if (in_valid) begin
                        d_q[0] <= in_data;
                        p_q[0] <= in_perr;
                    end
                    for (int i = 1; i < stages; i++) begin
                        v_q[i] <= v_q[i-1];
                        if (v_q[i-1]) begin
                            d_q[i] <= d_q[i-1];
                            p_q[i] <= p_q[i-1];
                        end
                    end
                end
            end

            assign out_valid = v_q[stages-1];
            assign out_data  = d_q[stages-1];
            assign out_perr  = p_q[stages-1];
        end
    endgenerate

endmodule

// File: rtl/sram_pipe.sv
// Byte-enable 1R1W SRAM with configurable read latency, write-first
// collision merge and post-reset zero sweep; optional SRAM_PARITY_EN.
// Ports: CLK, RST, READ_ADDR/OE -> DATA_OUT/RD_VALID/PERR,
//        WRITE_ADDR/DATA_IN/BE/WE, READY.
module sram_pipe
    import sram_pipe_pkg::*;
#(
    parameter int address_width  = 22,
    parameter int data_width     = 2,
    parameter int read_latency   = 1,
    parameter int clear_on_reset = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [address_width-1:0]   READ_ADDR,
    input  logic                       OE,
    output logic [(8<<data_width)-1:0] DATA_OUT,
    output logic                       RD_VALID,
    input  logic [address_width-1:0]   WRITE_ADDR,
    input  logic [(8<<data_width)-1:0] DATA_IN,
    input  logic [(1<<data_width)-1:0] BE,
    input  logic                       WE,
    output logic                       READY,
    output logic                       PERR
);

    localparam int NB    = 1 << data_width;
    localparam int DW    = 8 * NB;
    localparam int IW    = address_width - data_width;
    localparam int DEPTH = words_of(address_width, data_width);

    generate
        if (read_latency < 1 || read_latency > MAX_READ_LATENCY) begin : g_bad_lat
            $error("sram_pipe: read_latency must be 1..4");
        end
        if (data_width > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^{READ_ADDR[data_width-1:0],
                                  WRITE_ADDR[data_width-1:0]};
        end
    endgenerate

    logic [DW-1:0] mem [DEPTH];
`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
`endif

    state_t  state, state_d;
    logic [IW-1:0] ptr;
    logic    ready;

    logic [IW-1:0] rd_idx, wr_idx;
    logic    rd_acc, wr_acc, collide, clearing;

    assign rd_idx   = READ_ADDR[address_width-1:data_width];
    assign wr_idx   = WRITE_ADDR[address_width-1:data_width];
    assign rd_acc   = OE & ready & ~RST;
    assign wr_acc   = WE & ready & ~RST;
    assign collide  = rd_acc & wr_acc & (rd_idx == wr_idx);
    assign clearing = ~RST & (state == CLEAR);

    always_comb begin
        state_d = state;
        if (RST) begin
            state_d = (clear_on_reset != 0) ? CLEAR : RUN;
        end else if (state == CLEAR && ptr == IW'(DEPTH - 1)) begin
            state_d = RUN;
        end
    end

    // READY follows the next state so it rises on the edge that
    // completes the sweep (or the first edge out of reset).
    always_ff @(posedge CLK) begin
        state <= state_d;
        if (RST) begin
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            if (state == CLEAR) ptr <= ptr + 1'b1;
            ready <= (state_d == RUN);
        end
    end

    always_ff @(posedge CLK) begin
        if (clearing) begin
            mem[ptr] <= '0;
`ifdef SRAM_PARITY_EN
            par_mem[ptr] <= '0;
`endif
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (BE[b]) begin
                    mem[wr_idx][8*b +: 8] <= DATA_IN[8*b +: 8];
`ifdef SRAM_PARITY_EN
                    par_mem[wr_idx][b] <= byte_parity(DATA_IN[8*b +: 8]);
`endif
                end
            end
        end
    end

    logic [DW-1:0] rd_word, rd_merged;
    logic          rd_perr;

    // Write-first merge; forwarded bytes carry fresh parity, never flag.
    always_comb begin
        rd_word   = mem[rd_idx];
        rd_merged = rd_word;
        rd_perr   = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (collide && BE[b]) begin
                rd_merged[8*b +: 8] = DATA_IN[8*b +: 8];
            end else begin
`ifdef SRAM_PARITY_EN
                rd_perr = rd_perr |
                    (par_mem[rd_idx][b] ^ byte_parity(rd_word[8*b +: 8]));
`endif
            end
        end
    end

    logic          s1_valid, s1_perr;
    logic [DW-1:0] s1_data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_perr  <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_merged;
                s1_perr <= rd_perr;
            end
        end
    end

    logic out_perr;

    sram_rd_pipe #(
        .stages (read_latency - 1),
        .width  (DW)
    ) u_rd_pipe (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .in_perr   (s1_perr),
        .out_valid (RD_VALID),
        .out_data  (DATA_OUT),
        .out_perr  (out_perr)
    );

    assign PERR  = RD_VALID & out_perr;
    assign READY = ready;

endmodule
